// File: rtl/csa_addsub_pipe.sv
// Two-stage pipelined carry-select add/subtract unit with valid/ready on both sides.
// Stage 1 resolves the low half and both carry hypotheses for the high half;
// stage 2 picks the high half with the registered low-half carry and drives the outputs.
module csa_addsub_pipe #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic [CNT_W-1:0] done_cnt
);

    localparam int unsigned L = WIDTH / 2;

    // Stage 1 state
    logic         s1_valid;
    logic [L-1:0] s1_lo;
    logic         s1_c_mid;
    logic [L-1:0] s1_hi0;
    logic         s1_c_h0;
    logic [L-1:0] s1_hi1;
    logic         s1_c_h1;
    logic         s1_a_msb;
    logic         s1_beff_msb;

    // Operand prep and stage 1 arithmetic
    logic [WIDTH-1:0] b_eff;
    logic             cin;
    logic [L:0]       lo_sum;
    logic [L:0]       hi0_sum;
    logic [L:0]       hi1_sum;

    // Handshake
    logic s2_accept;
    logic in_fire;
    logic out_fire;

    // Stage 2 next values
    logic [L-1:0]     hi_sel;
    logic [WIDTH-1:0] result_d;
    logic             cout_d;
    logic             ovf_d;

    // Handshake decode; in_ready depends on out_ready but never on in_valid.
    always_comb begin
        s2_accept = !out_valid || out_ready;
        in_ready  = !s1_valid || s2_accept;
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
    end

    // Subtract as A + ~B + 1, then low block plus both high-block carry hypotheses.
    always_comb begin
        b_eff   = mode ? ~b : b;
        cin     = mode;
        lo_sum  = {1'b0, a[L-1:0]} + {1'b0, b_eff[L-1:0]} + {{L{1'b0}}, cin};
        hi0_sum = {1'b0, a[WIDTH-1:L]} + {1'b0, b_eff[WIDTH-1:L]};
        hi1_sum = {1'b0, a[WIDTH-1:L]} + {1'b0, b_eff[WIDTH-1:L]} + {{L{1'b0}}, 1'b1};
    end

    // Carry select on the registered low-block carry, plus signed overflow.
    always_comb begin
        hi_sel   = s1_c_mid ? s1_hi1 : s1_hi0;
        result_d = {hi_sel, s1_lo};
        cout_d   = s1_c_mid ? s1_c_h1 : s1_c_h0;
        ovf_d    = (s1_a_msb == s1_beff_msb) && (hi_sel[L-1] != s1_a_msb);
    end

    // Stage 1 register: capture on input handshake, drain when stage 2 takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_lo       <= '0;
            s1_c_mid    <= 1'b0;
            s1_hi0      <= '0;
            s1_c_h0     <= 1'b0;
            s1_hi1      <= '0;
            s1_c_h1     <= 1'b0;
            s1_a_msb    <= 1'b0;
            s1_beff_msb <= 1'b0;
        end else if (in_fire) begin
            s1_valid    <= 1'b1;
            s1_lo       <= lo_sum[L-1:0];
            s1_c_mid    <= lo_sum[L];
            s1_hi0      <= hi0_sum[L-1:0];
            s1_c_h0     <= hi0_sum[L];
            s1_hi1      <= hi1_sum[L-1:0];
            s1_c_h1     <= hi1_sum[L];
            s1_a_msb    <= a[WIDTH-1];
            s1_beff_msb <= b_eff[WIDTH-1];
        end else if (s2_accept) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2 register: load when the output slot is free or being emptied, else hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (s2_accept) begin
            out_valid <= s1_valid;
            // Only move real data so the outputs stay quiet across bubbles.
            if (s1_valid) begin
                result <= result_d;
                cout   <= cout_d;
                ovf    <= ovf_d;
            end
        end
    end

    // Completed-result counter, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_cnt <= '0;
        end else if (out_fire) begin
            done_cnt <= done_cnt + CNT_W'(1);
        end
    end

endmodule
